axi4_lite_master_arbiter: RTL

Shares one AXI4-Lite master (write/read start-busy command interface) between NUM_REQ requesters, e.g. core instruction fetch, data port and benchmark/debug port.
- Round-robin arbitration, one outstanding transaction at a time.
- Sequences start pulses and tracks busy to detect completion.
- Returns read data or error to the granted requester.
- Sits between the RISC-V core memory ports and the AXI4-Lite master.

---
 rtl/axi4_lite_arb_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/axi4_lite_master_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/axi4_lite_arb_pkg.sv
// rtl/axi4_lite_arb_pkg.sv - shared types and helpers for the AXI4-Lite master arbiter
package axi4_lite_arb_pkg;

   localparam int CMD_ADDR_W = 32;
   localparam int CMD_DATA_W = 32;
   localparam int STRB_W     = 4;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   typedef struct packed {
      logic                  write;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_DATA_W-1:0] wdata;
      logic [STRB_W-1:0]     strobe;
   } arb_cmd_t;

   // Wait counter must be able to hold TIMEOUT; a disabled timeout still needs one bit.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting after the last grant
module rr_arbiter
   import axi4_lite_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IW      = idx_width(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      grant_idx
);

   // Scan offsets from farthest to nearest so the nearest requester after last_grant wins.
   always_comb begin
      int j;
      j         = 0;
      grant     = '0;
      grant_idx = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         j = int'(last_grant) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (req[j]) begin
            grant     = NUM_REQ'(1) << j;
            grant_idx = IW'(j);
         end
      end
   end

endmodule

// File: rtl/axi4_lite_master_arbiter.sv
// rtl/axi4_lite_master_arbiter.sv - shares one AXI4-Lite start/busy master among several requesters
module axi4_lite_master_arbiter
   import axi4_lite_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = CMD_ADDR_W,
   parameter int DATA_WIDTH = CMD_DATA_W,
   parameter int TIMEOUT    = 1024
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ-1:0]           req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   input  logic [NUM_REQ*4-1:0]         req_strobe,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           resp_valid,
   output logic [DATA_WIDTH-1:0]        resp_rdata,
   output logic                         resp_err,
   output logic                         write_start,
   output logic [ADDR_WIDTH-1:0]        write_addr,
   output logic [DATA_WIDTH-1:0]        write_data,
   output logic [3:0]                   write_strobe,
   input  logic                         write_busy,
   output logic                         read_start,
   output logic [ADDR_WIDTH-1:0]        read_addr,
   input  logic [DATA_WIDTH-1:0]        read_data,
   input  logic                         read_busy
);

   localparam int IW = idx_width(NUM_REQ);
   localparam int CW = cnt_width(TIMEOUT);

   arb_state_t         state;
   logic [IW-1:0]      last_grant;
   logic [IW-1:0]      g_q;
   logic [IW-1:0]      win_idx;
   logic [NUM_REQ-1:0] win_grant;
   arb_cmd_t           cmd_q;
   arb_cmd_t           win_cmd;
   logic               seen_busy;
   logic [CW-1:0]      wait_cnt;
   logic               busy;
   logic               done;
   logic               timed_out;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (win_grant),
      .grant_idx  (win_idx)
   );

   // A grant is offered only while idle and out of reset.
   assign req_ready = (state == IDLE && rst) ? win_grant : '0;

   // Pull the winning requester's command out of the packed buses.
   always_comb begin
      win_cmd        = '0;
      win_cmd.write  = req_write[win_idx];
      win_cmd.addr   = CMD_ADDR_W'(req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH]);
      win_cmd.wdata  = CMD_DATA_W'(req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH]);
      win_cmd.strobe = req_strobe[int'(win_idx)*STRB_W +: STRB_W];
   end

   assign busy      = cmd_q.write ? write_busy : read_busy;
   assign done      = seen_busy && !busy;
   // Counter reaches TIMEOUT-1 at the end of this cycle, so leave WAIT now.
   assign timed_out = (TIMEOUT != 0) && (int'(wait_cnt) + 2 >= TIMEOUT);

   // The master sees the latched command for the whole transaction.
   assign write_addr   = ADDR_WIDTH'(cmd_q.addr);
   assign read_addr    = ADDR_WIDTH'(cmd_q.addr);
   assign write_data   = DATA_WIDTH'(cmd_q.wdata);
   assign write_strobe = cmd_q.strobe;

   // Transaction sequencer: accept, pulse start, watch busy rise and fall, report.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         last_grant  <= IW'(NUM_REQ - 1);
         g_q         <= '0;
         cmd_q       <= '0;
         seen_busy   <= 1'b0;
         wait_cnt    <= '0;
         write_start <= 1'b0;
         read_start  <= 1'b0;
         resp_valid  <= '0;
         resp_rdata  <= '0;
         resp_err    <= 1'b0;
      end else begin
         write_start <= 1'b0;
         read_start  <= 1'b0;
         resp_valid  <= '0;
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  cmd_q       <= win_cmd;
                  g_q         <= win_idx;
                  write_start <= win_cmd.write;
                  read_start  <= !win_cmd.write;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (busy) seen_busy <= 1'b1;
               wait_cnt <= wait_cnt + CW'(1);
               if (done) begin
                  resp_rdata <= cmd_q.write ? '0 : read_data;
                  resp_err   <= 1'b0;
                  resp_valid <= NUM_REQ'(1) << g_q;
                  state      <= RESP;
               end else if (timed_out) begin
                  resp_rdata <= '0;
                  resp_err   <= 1'b1;
                  resp_valid <= NUM_REQ'(1) << g_q;
                  state      <= RESP;
               end
            end
            RESP: begin
               last_grant <= g_q;
               seen_busy  <= 1'b0;
               wait_cnt   <= '0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
